// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin valid/ready arbiter feeding the single write
// port of a synchronous fifo. Beats are registered into one output stage and
// gated by the fifo's registered almost-full flag.
// Optional build macro FIFO_ARB_BURST_EN: owners keep the grant for up to
// MAX_BURST beats; otherwise the grant is re-arbitrated after every beat.
module fifo_write_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [REQUESTERS-1:0]            req_valid_i,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data_i,
  output logic [REQUESTERS-1:0]            req_ready_o,
  output logic [REQUESTERS-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]            fifo_write_data_o,
  output logic                             fifo_write_enable_o,
  input  logic                             fifo_almost_full_i
);

  localparam int unsigned OWNER_W = $clog2(REQUESTERS);

  if (REQUESTERS < 2 || REQUESTERS > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("fifo_write_arbiter: parameter out of range");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_r;
  logic [OWNER_W-1:0]   owner_r;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0]     beat_cnt_r;
`endif

  logic                  owner_valid;
  logic                  owner_xfer;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  limit_hit;
  logic                  excl_found;
  logic [OWNER_W-1:0]    excl_idx;
  logic                  incl_found;
  logic [OWNER_W-1:0]    incl_idx;
  logic                  rearb;
  logic                  next_found;
  logic [OWNER_W-1:0]    next_idx;

  // Index 'step' positions after 'base', wrapping modulo REQUESTERS.
  function automatic logic [OWNER_W-1:0] rr_index(input logic [OWNER_W-1:0] base,
                                                  input int unsigned step);
    int unsigned idx;
    idx = 32'(base) + step;
    if (idx >= REQUESTERS) idx = idx - REQUESTERS;
    return OWNER_W'(idx);
  endfunction

  assign owner_valid = req_valid_i[owner_r];
  assign owner_data  = req_data_i[32'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
  assign owner_xfer  = (state_r == ST_GRANT) && !fifo_almost_full_i && owner_valid;

`ifdef FIFO_ARB_BURST_EN
  assign limit_hit = (beat_cnt_r == CNT_W'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b1;
`endif

  // Only the current owner sees ready, and only while the fifo has room.
  always_comb begin
    req_ready_o = '0;
    if (state_r == ST_GRANT && !fifo_almost_full_i) req_ready_o[owner_r] = 1'b1;
  end

  // Round-robin search starting after the owner; the owner itself is the last candidate.
  always_comb begin
    excl_found = 1'b0;
    excl_idx   = owner_r;
    for (int unsigned k = 1; k < REQUESTERS; k++) begin
      if (!excl_found && req_valid_i[rr_index(owner_r, k)]) begin
        excl_found = 1'b1;
        excl_idx   = rr_index(owner_r, k);
      end
    end
    incl_found = excl_found || owner_valid;
    incl_idx   = excl_found ? excl_idx : owner_r;
  end

  // Decide whether ownership is re-evaluated this cycle and who would win.
  always_comb begin
    rearb      = 1'b0;
    next_found = incl_found;
    next_idx   = incl_idx;
    if (state_r == ST_IDLE) begin
      rearb = 1'b1;
    end else if (!fifo_almost_full_i) begin
      if (!owner_valid) begin
        rearb      = 1'b1;
        next_found = excl_found;
        next_idx   = excl_idx;
      end else if (limit_hit) begin
        rearb = 1'b1;
      end
    end
  end

  // State, owner, grant, beat counter and the registered fifo write stage.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r             <= ST_IDLE;
      owner_r             <= OWNER_W'(REQUESTERS - 1);
      grant_o             <= '0;
      fifo_write_enable_o <= 1'b0;
      fifo_write_data_o   <= '0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt_r          <= '0;
`endif
    end else begin
      fifo_write_enable_o <= owner_xfer;
      if (owner_xfer) fifo_write_data_o <= owner_data;
      if (rearb) begin
`ifdef FIFO_ARB_BURST_EN
        beat_cnt_r <= '0;
`endif
        if (next_found) begin
          state_r <= ST_GRANT;
          owner_r <= next_idx;
          grant_o <= REQUESTERS'(1) << next_idx;
        end else begin
          state_r <= ST_IDLE;
          grant_o <= '0;
        end
      end else begin
`ifdef FIFO_ARB_BURST_EN
        if (owner_xfer) beat_cnt_r <= beat_cnt_r + 8'd1;
`endif
      end
    end
  end

endmodule
